// File: rtl/gfx_pkg.sv
// Shared definitions for the gfx_blit block: copy modes, FSM states,
// register-bus addresses and CTRL bit positions.
package gfx_pkg;

  typedef enum logic [1:0] {
    MODE_COPY_ALL = 2'd0,
    MODE_COPY_KEY = 2'd1,
    MODE_FILL     = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] REG_SRC_X  = 4'h0;
  localparam logic [3:0] REG_SRC_Y  = 4'h1;
  localparam logic [3:0] REG_DST_X  = 4'h2;
  localparam logic [3:0] REG_DST_Y  = 4'h3;
  localparam logic [3:0] REG_WIDTH  = 4'h4;
  localparam logic [3:0] REG_HEIGHT = 4'h5;
  localparam logic [3:0] REG_XMASK  = 4'h6;
  localparam logic [3:0] REG_YMASK  = 4'h7;
  localparam logic [3:0] REG_KEY    = 4'h8;
  localparam logic [3:0] REG_FILL   = 4'h9;
  localparam logic [3:0] REG_CTRL   = 4'hA;

  localparam int unsigned CTRL_ABORT_BIT = 6;
  localparam int unsigned CTRL_START_BIT = 7;

endpackage

// File: rtl/gfx_blit_addr_gen.sv
// X/Y traversal counter and address generator for gfx_blit.
// Holds the pixel currently being issued; advances row-major on step_i.
//   clk_i, rst_ni       : clock, async active-low reset
//   load_i              : restart at pixel (0,0) from the origin inputs
//   step_i              : advance to the next pixel
//   src_*/dst_*/width/height/masks : configuration (stable while busy)
//   src_addr_o          : masked source address {Y,X}
//   dst_addr_o          : destination address {Y,X}, modulo wrap
//   last_o              : current pixel is the final one of the rectangle
module gfx_blit_addr_gen
  import gfx_pkg::*;
#(
  parameter int unsigned SRC_XW = 8,
  parameter int unsigned SRC_YW = 5,
  parameter int unsigned DST_XW = 8,
  parameter int unsigned DST_YW = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic [SRC_XW-1:0]        src_x_i,
  input  logic [SRC_YW-1:0]        src_y_i,
  input  logic [DST_XW-1:0]        dst_x_i,
  input  logic [DST_YW-1:0]        dst_y_i,
  input  logic [7:0]               width_i,
  input  logic [7:0]               height_i,
  input  logic [SRC_XW-1:0]        xmask_i,
  input  logic [SRC_YW-1:0]        ymask_i,
  output logic [SRC_YW+SRC_XW-1:0] src_addr_o,
  output logic [DST_YW+DST_XW-1:0] dst_addr_o,
  output logic                     last_o
);

  logic [7:0]        i_q, j_q;
  logic [SRC_XW-1:0] sx_q;
  logic [SRC_YW-1:0] sy_q;
  logic [DST_XW-1:0] dx_q;
  logic [DST_YW-1:0] dy_q;
  logic              row_end;

  assign row_end = (i_q == width_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_q  <= '0;
      j_q  <= '0;
      sx_q <= '0;
      sy_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
    end else if (load_i) begin
      i_q  <= '0;
      j_q  <= '0;
      sx_q <= src_x_i;
      sy_q <= src_y_i;
      dx_q <= dst_x_i;
      dy_q <= dst_y_i;
    end else if (step_i) begin
      if (row_end) begin
        i_q  <= '0;
        j_q  <= j_q + 8'd1;
        sx_q <= src_x_i;
        dx_q <= dst_x_i;
        sy_q <= sy_q + 1'b1;
        dy_q <= dy_q + 1'b1;
      end else begin
        i_q  <= i_q + 8'd1;
        sx_q <= sx_q + 1'b1;
        dx_q <= dx_q + 1'b1;
      end
    end
  end

  // Running coordinates are kept unmasked so tiling repeats correctly.
  assign src_addr_o = {sy_q & ymask_i, sx_q & xmask_i};
  assign dst_addr_o = {dy_q, dx_q};
  assign last_o     = row_end && (j_q == height_i);

endmodule

// File: rtl/gfx_blit.sv
// Rectangle blitter: copies, colour-keys or fills a (WIDTH+1)x(HEIGHT+1)
// region into VRAM at one pixel per unstalled cycle.
//   i_clk, i_rst_b         : clock, async active-low reset
//   i_cfg_*                : 8-bit register bus (ce/we active low)
//   o_src_addr/o_src_re_b  : source read port, data on i_src_data next cycle
//   o_dst_addr/data/we_b   : destination write port
//   i_free_vbus_b          : VRAM bus free when low; high freezes the block
//   o_busy, o_done         : status; o_done pulses one cycle at the end
module gfx_blit
  import gfx_pkg::*;
#(
  parameter int unsigned SRC_XW = 8,
  parameter int unsigned SRC_YW = 5,
  parameter int unsigned DST_XW = 8,
  parameter int unsigned DST_YW = 8,
  parameter int unsigned DW     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_b,
  input  logic                     i_cfg_ce_b,
  input  logic                     i_cfg_we_b,
  input  logic [3:0]               i_cfg_addr,
  input  logic [7:0]               i_cfg_data,
  output logic [SRC_YW+SRC_XW-1:0] o_src_addr,
  output logic                     o_src_re_b,
  input  logic [DW-1:0]            i_src_data,
  output logic [DST_YW+DST_XW-1:0] o_dst_addr,
  output logic [DW-1:0]            o_dst_data,
  output logic                     o_dst_we_b,
  input  logic                     i_free_vbus_b,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int unsigned DAW = DST_YW + DST_XW;

  logic [SRC_XW-1:0] src_x_q, xmask_q;
  logic [SRC_YW-1:0] src_y_q, ymask_q;
  logic [DST_XW-1:0] dst_x_q;
  logic [DST_YW-1:0] dst_y_q;
  logic [7:0]        width_q, height_q;
  logic [DW-1:0]     key_q, fill_q;
  mode_e             mode_q;

  state_e            state_q;
  logic              busy_q, done_q, re_q, we_q, s1_vld_q;
  logic [DAW-1:0]    s1_dst_q, dst_addr_q;
  logic [DW-1:0]     dst_data_q;

  logic              cfg_wr, ctrl_wr, start, abort, adv, gen_step, gen_last, px_skip;
  mode_e             cfg_mode;
  logic [DAW-1:0]    gen_dst;

  assign cfg_wr   = !i_cfg_ce_b && !i_cfg_we_b;
  assign ctrl_wr  = cfg_wr && (i_cfg_addr == REG_CTRL);
  assign cfg_mode = mode_e'(i_cfg_data[1:0]);
  assign start    = ctrl_wr && i_cfg_data[CTRL_START_BIT] && (state_q == S_IDLE);
  assign abort    = ctrl_wr && i_cfg_data[CTRL_ABORT_BIT] &&
                    ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign adv      = !i_free_vbus_b;
  assign gen_step = (state_q == S_RUN) && adv && !gen_last && !abort;
  assign px_skip  = (mode_q == MODE_COPY_KEY) && (i_src_data == key_q);

  gfx_blit_addr_gen #(
    .SRC_XW(SRC_XW),
    .SRC_YW(SRC_YW),
    .DST_XW(DST_XW),
    .DST_YW(DST_YW)
  ) u_addr_gen (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_b),
    .load_i     (start),
    .step_i     (gen_step),
    .src_x_i    (src_x_q),
    .src_y_i    (src_y_q),
    .dst_x_i    (dst_x_q),
    .dst_y_i    (dst_y_q),
    .width_i    (width_q),
    .height_i   (height_q),
    .xmask_i    (xmask_q),
    .ymask_i    (ymask_q),
    .src_addr_o (o_src_addr),
    .dst_addr_o (gen_dst),
    .last_o     (gen_last)
  );

  // Configuration registers accept writes only while idle.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      src_x_q  <= '0;
      src_y_q  <= '0;
      dst_x_q  <= '0;
      dst_y_q  <= '0;
      width_q  <= '0;
      height_q <= '0;
      xmask_q  <= '1;
      ymask_q  <= '1;
      key_q    <= '0;
      fill_q   <= '0;
      mode_q   <= MODE_COPY_ALL;
    end else if (cfg_wr && (state_q == S_IDLE)) begin
      unique case (i_cfg_addr)
        REG_SRC_X:  src_x_q  <= SRC_XW'(i_cfg_data);
        REG_SRC_Y:  src_y_q  <= SRC_YW'(i_cfg_data);
        REG_DST_X:  dst_x_q  <= DST_XW'(i_cfg_data);
        REG_DST_Y:  dst_y_q  <= DST_YW'(i_cfg_data);
        REG_WIDTH:  width_q  <= i_cfg_data;
        REG_HEIGHT: height_q <= i_cfg_data;
        REG_XMASK:  xmask_q  <= SRC_XW'(i_cfg_data);
        REG_YMASK:  ymask_q  <= SRC_YW'(i_cfg_data);
        REG_KEY:    key_q    <= DW'(i_cfg_data);
        REG_FILL:   fill_q   <= DW'(i_cfg_data);
        REG_CTRL:   mode_q   <= cfg_mode;
        default:    ;
      endcase
    end
  end

  // Pipeline: issue (RUN) -> stage 1 captures source data -> write slot.
  // A stall freezes every stage; the strobe is masked combinationally so
  // a frozen write slot is replayed on release.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      re_q       <= 1'b1;
      we_q       <= 1'b1;
      s1_vld_q   <= 1'b0;
      s1_dst_q   <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          we_q     <= 1'b1;
          s1_vld_q <= 1'b0;
          done_q   <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            re_q    <= (cfg_mode == MODE_FILL);
          end
        end
        S_RUN, S_DRAIN: begin
          if (abort) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            re_q     <= 1'b1;
            we_q     <= 1'b1;
            s1_vld_q <= 1'b0;
          end else if (adv) begin
            we_q <= !(s1_vld_q && !px_skip);
            if (s1_vld_q) begin
              dst_addr_q <= s1_dst_q;
              dst_data_q <= (mode_q == MODE_FILL) ? fill_q : i_src_data;
            end
            if (state_q == S_RUN) begin
              s1_vld_q <= 1'b1;
              s1_dst_q <= gen_dst;
              if (gen_last) begin
                state_q <= S_DRAIN;
                re_q    <= 1'b1;
              end
            end else begin
              s1_vld_q <= 1'b0;
              if (!s1_vld_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_src_re_b = re_q | i_free_vbus_b;
  assign o_dst_we_b = we_q | i_free_vbus_b;
  assign o_dst_addr = dst_addr_q;
  assign o_dst_data = dst_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_gfx_blit.sv
// Directed self-checking bench for gfx_blit.
module tb_gfx_blit;
  import gfx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b, ce_b, we_b, free_b;
  logic [3:0]  addr;
  logic [7:0]  data;
  logic [12:0] src_addr;
  logic        src_re_b;
  logic [7:0]  src_data = '0;
  logic [15:0] dst_addr;
  logic [7:0]  dst_data;
  logic        dst_we_b, busy, done;

  always #5 clk = ~clk;

  gfx_blit #(
    .SRC_XW(8),
    .SRC_YW(5),
    .DST_XW(8),
    .DST_YW(8),
    .DW(8)
  ) dut (
    .i_clk        (clk),
    .i_rst_b      (rst_b),
    .i_cfg_ce_b   (ce_b),
    .i_cfg_we_b   (we_b),
    .i_cfg_addr   (addr),
    .i_cfg_data   (data),
    .o_src_addr   (src_addr),
    .o_src_re_b   (src_re_b),
    .i_src_data   (src_data),
    .o_dst_addr   (dst_addr),
    .o_dst_data   (dst_data),
    .o_dst_we_b   (dst_we_b),
    .i_free_vbus_b(free_b),
    .o_busy       (busy),
    .o_done       (done)
  );

  // Source memory: registered read, data held while read enable is high.
  logic [7:0] smem [0:8191];
  always @(posedge clk) if (!src_re_b) src_data <= smem[src_addr];

  // Bus monitor, sampled on the falling edge.
  int unsigned cyc = 0, run_cyc = 0, done_cnt = 0;
  logic        busy_prev = 1'b0;
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int unsigned wc_q[$];
  logic [12:0] sa_q[$];

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    busy_prev <= busy;
    if (busy && !busy_prev) run_cyc <= cyc;
    if (done) done_cnt <= done_cnt + 1;
    if (!dst_we_b) begin
      wa_q.push_back(dst_addr);
      wd_q.push_back(dst_data);
      wc_q.push_back(cyc);
    end
    if (!src_re_b) sa_q.push_back(src_addr);
  end

  int unsigned n_tests = 0, n_fail = 0;
  logic [15:0] ea_q[$];
  logic [7:0]  ed_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    ce_b = 1'b0; we_b = 1'b0; addr = a; data = d;
    @(negedge clk); #1;
    ce_b = 1'b1; we_b = 1'b1;
  endtask

  task automatic setup(input logic [7:0] sx, sy, dx, dy, w, h);
    cfg(REG_SRC_X, sx);  cfg(REG_SRC_Y, sy);
    cfg(REG_DST_X, dx);  cfg(REG_DST_Y, dy);
    cfg(REG_WIDTH, w);   cfg(REG_HEIGHT, h);
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    while (!done && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  // Plain-copy reference for unmasked source coordinates.
  task automatic exp_copy(input int unsigned sx, sy, dx, dy, w, h);
    logic [12:0] a;
    ea_q.delete(); ed_q.delete();
    for (int unsigned j = 0; j <= h; j++)
      for (int unsigned i = 0; i <= w; i++) begin
        a = {5'(sy + j), 8'(sx + i)};
        ea_q.push_back({8'(dy + j), 8'(dx + i)});
        ed_q.push_back(smem[a]);
      end
  endtask

  task automatic check_wr(input string tag, input int unsigned base);
    check({tag, "_cnt"}, 32'(wa_q.size() - base), 32'(ea_q.size()));
    for (int unsigned i = 0; i < ea_q.size() && base + i < wa_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[base+i]), 32'(ea_q[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(wd_q[base+i]), 32'(ed_q[i]));
    end
  endtask

  initial begin
    int unsigned base, sbase, d0, wb, n;
    logic [12:0] xa;
    rst_b = 1'b0; ce_b = 1'b1; we_b = 1'b1; addr = '0; data = '0; free_b = 1'b0;
    for (int unsigned a = 0; a < 8192; a++)
      smem[a] = 8'((a % 256) * 3 + (a / 256) * 37 + 5);
    smem[13'h200] = 8'h00; smem[13'h201] = 8'h5A;
    smem[13'h202] = 8'h00; smem[13'h203] = 8'h33;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_done",  {31'd0, done},     32'd0);
    check("rst_re_b",  {31'd0, src_re_b}, 32'd1);
    check("rst_we_b",  {31'd0, dst_we_b}, 32'd1);
    check("rst_saddr", 32'(src_addr),     32'd0);
    check("rst_daddr", 32'(dst_addr),     32'd0);
    check("rst_ddata", 32'(dst_data),     32'd0);
    rst_b = 1'b1;

    // COPY_ALL 4x2 to (10,20)
    setup(8'd0, 8'd0, 8'd10, 8'd20, 8'd3, 8'd1);
    base = wa_q.size(); d0 = done_cnt;
    cfg(REG_CTRL, 8'h80);
    wait_done("t1_done");
    exp_copy(0, 0, 10, 20, 3, 1);
    check_wr("t1", base);
    if (wa_q.size() > base) check("t1_first_lat", wc_q[base] - run_cyc, 32'd2);
    else check("t1_first_lat", 32'hFFFF, 32'd2);
    check("t1_donecnt", done_cnt - d0, 32'd1);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // COPY_KEY with key 0 on row {00,5A,00,33}
    setup(8'd0, 8'd2, 8'd0, 8'd0, 8'd3, 8'd0);
    cfg(REG_KEY, 8'h00);
    base = wa_q.size();
    cfg(REG_CTRL, 8'h81);
    wait_done("t2_done");
    ea_q.delete(); ed_q.delete();
    ea_q.push_back(16'h0001); ed_q.push_back(8'h5A);
    ea_q.push_back(16'h0003); ed_q.push_back(8'h33);
    check_wr("t2", base);

    // FILL 3x3 with wrap at (254,255)
    setup(8'd0, 8'd0, 8'd254, 8'd255, 8'd2, 8'd2);
    cfg(REG_FILL, 8'hC3);
    base = wa_q.size(); sbase = sa_q.size();
    cfg(REG_CTRL, 8'h82);
    wait_done("t3_done");
    ea_q.delete(); ed_q.delete();
    ea_q = '{16'hFFFE, 16'hFFFF, 16'hFF00, 16'h00FE, 16'h00FF, 16'h0000,
             16'h01FE, 16'h01FF, 16'h0100};
    for (int unsigned i = 0; i < 9; i++) ed_q.push_back(8'hC3);
    check_wr("t3", base);
    check("t3_no_src_read", 32'(sa_q.size() - sbase), 32'd0);

    // XMASK=3 tiling on an 8-wide row
    cfg(REG_XMASK, 8'h03);
    setup(8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd0);
    sbase = sa_q.size();
    cfg(REG_CTRL, 8'h80);
    wait_done("t4_done");
    check("t4_src_cnt", 32'(sa_q.size() - sbase), 32'd8);
    for (int unsigned i = 0; i < 8 && sbase + i < sa_q.size(); i++) begin
      xa = 13'(i % 4);
      check($sformatf("t4_srcx%0d", i), 32'(sa_q[sbase+i]), 32'(xa));
    end
    cfg(REG_XMASK, 8'hFF);

    // 5-cycle bus stall mid-copy
    setup(8'd0, 8'd0, 8'd10, 8'd20, 8'd3, 8'd1);
    base = wa_q.size(); d0 = done_cnt;
    cfg(REG_CTRL, 8'h80);
    repeat (2) @(negedge clk);
    #1;
    free_b = 1'b1;
    wb = wa_q.size();
    repeat (5) @(negedge clk);
    #1;
    check("t5_no_we_in_stall", 32'(wa_q.size()), 32'(wb));
    free_b = 1'b0;
    wait_done("t5_done");
    exp_copy(0, 0, 10, 20, 3, 1);
    check_wr("t5", base);
    check("t5_donecnt", done_cnt - d0, 32'd1);

    // Abort after the third write
    setup(8'd0, 8'd0, 8'd10, 8'd20, 8'd3, 8'd1);
    base = wa_q.size(); d0 = done_cnt;
    cfg(REG_CTRL, 8'h80);
    n = 0;
    while (wa_q.size() - base < 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("t6_reach3", 32'(wa_q.size() - base), 32'd3);
    ce_b = 1'b0; we_b = 1'b0; addr = REG_CTRL; data = 8'h40;
    @(negedge clk); #1;
    ce_b = 1'b1; we_b = 1'b1;
    wait_done("t6_done");
    repeat (5) @(negedge clk);
    #1;
    check("t6_wr_cnt", 32'(wa_q.size() - base), 32'd3);
    check("t6_donecnt", done_cnt - d0, 32'd1);
    check("t6_idle", {31'd0, busy}, 32'd0);

    // Reset during a write slot
    setup(8'd0, 8'd0, 8'd10, 8'd20, 8'd3, 8'd1);
    base = wa_q.size();
    cfg(REG_CTRL, 8'h80);
    n = 0;
    while (wa_q.size() == base && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("t7_we_low", {31'd0, dst_we_b}, 32'd0);
    rst_b = 1'b0;
    #1;
    check("t7_we_rst", {31'd0, dst_we_b}, 32'd1);
    check("t7_busy_rst", {31'd0, busy}, 32'd0);
    wb = wa_q.size();
    repeat (3) @(negedge clk);
    #1;
    check("t7_no_more_we", 32'(wa_q.size()), 32'(wb));
    rst_b = 1'b1;

    // Masks return to all-ones after reset: plain 8-wide source row
    setup(8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd0);
    sbase = sa_q.size();
    cfg(REG_CTRL, 8'h80);
    wait_done("t8_done");
    check("t8_src_cnt", 32'(sa_q.size() - sbase), 32'd8);
    for (int unsigned i = 0; i < 8 && sbase + i < sa_q.size(); i++)
      check($sformatf("t8_srcx%0d", i), 32'(sa_q[sbase+i]), i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
